// File: rtl/model_vertex_transform.sv
`default_nettype none
// ============================================================================
// Module      : model_vertex_transform
// Description : Applies a snapshotted 4x4 Q8.8 model matrix to object-space
//               vertices (w = 1.0) using one time-shared signed MAC unit,
//               16 MAC cycles per vertex, with saturating Q8.8 outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module model_vertex_transform #(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 36
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0][15:0] model_matrix,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       vx,
    input  logic [15:0]       vy,
    input  logic [15:0]       vz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       ox,
    output logic [15:0]       oy,
    output logic [15:0]       oz,
    output logic [15:0]       ow,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [15:0] C_ONE     = 16'h0100;
    localparam logic [15:0] C_SAT_MAX = 16'h7FFF;
    localparam logic [15:0] C_SAT_MIN = 16'h8000;

    logic [1:0]              r_state;
    logic                    r_started;
    logic [3:0]              r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic [15:0][15:0]       r_m;
    logic [15:0]             r_vx;
    logic [15:0]             r_vy;
    logic [15:0]             r_vz;

    logic [1:0]              w_row;
    logic [1:0]              w_col;
    logic [15:0]             w_msel;
    logic [15:0]             w_vsel;
    logic signed [31:0]      w_ma;
    logic signed [31:0]      w_va;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_shift;
    logic [ACC_W-16:0]       w_hi;
    logic                    w_sat_pos;
    logic                    w_sat_neg;
    logic [15:0]             w_row_val;

    // in_ready is held low until the first edge after reset release
    assign in_ready = r_started && (r_state == S_IDLE);

    assign w_row  = r_idx[3:2];
    assign w_col  = r_idx[1:0];
    assign w_msel = r_m[r_idx];

    // Select the vertex component for the current matrix column (w = 1.0)
    always_comb begin
        w_vsel = C_ONE;
        case (w_col)
            2'd0:    w_vsel = r_vx;
            2'd1:    w_vsel = r_vy;
            2'd2:    w_vsel = r_vz;
            default: w_vsel = C_ONE;
        endcase
    end

    // Full-precision Q16.16 product; operands pre-extended so the low 32 bits are exact
    assign w_ma       = {{16{w_msel[15]}}, w_msel};
    assign w_va       = {{16{w_vsel[15]}}, w_vsel};
    assign w_prod     = w_ma * w_va;
    assign w_acc_next = r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};

    // Row result: arithmetic shift back to Q8.8 then clamp to the 16-bit range
    assign w_shift   = w_acc_next >>> FRAC_BITS;
    assign w_hi      = w_shift[ACC_W-1:15];
    assign w_sat_pos = ~w_shift[ACC_W-1] & (|w_hi);
    assign w_sat_neg =  w_shift[ACC_W-1] & ~(&w_hi);

    // Clamped row value
    always_comb begin
        w_row_val = w_shift[15:0];
        if (w_sat_pos) begin
            w_row_val = C_SAT_MAX;
        end else if (w_sat_neg) begin
            w_row_val = C_SAT_MIN;
        end
    end

    // Control FSM, input snapshot, MAC accumulation and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_started <= 1'b0;
            r_idx     <= 4'd0;
            r_acc     <= '0;
            r_m       <= '0;
            r_vx      <= 16'h0000;
            r_vy      <= 16'h0000;
            r_vz      <= 16'h0000;
            out_valid <= 1'b0;
            ox        <= 16'h0000;
            oy        <= 16'h0000;
            oz        <= 16'h0000;
            ow        <= 16'h0000;
            overflow  <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_m      <= model_matrix;
                        r_vx     <= vx;
                        r_vy     <= vy;
                        r_vz     <= vz;
                        r_idx    <= 4'd0;
                        r_acc    <= '0;
                        overflow <= 1'b0;
                        r_state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_col == 2'd3) begin
                        r_acc <= '0;
                        case (w_row)
                            2'd0:    ox <= w_row_val;
                            2'd1:    oy <= w_row_val;
                            2'd2:    oz <= w_row_val;
                            default: ow <= w_row_val;
                        endcase
                        if (w_sat_pos || w_sat_neg) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd15) begin
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_model_vertex_transform.sv
`default_nettype none
// ============================================================================
// Module      : tb_model_vertex_transform
// Description : Directed self-checking bench for model_vertex_transform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_model_vertex_transform;

    logic              Clk;
    logic              Reset;
    logic [15:0][15:0] model_matrix;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       vx, vy, vz;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       ox, oy, oz, ow;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    model_vertex_transform dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .model_matrix (model_matrix),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vx           (vx),
        .vy           (vy),
        .vz           (vz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ox           (ox),
        .oy           (oy),
        .oz           (oz),
        .ow           (ow),
        .overflow     (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Matrix builders
    task automatic set_identity();
        model_matrix     = '0;
        model_matrix[0]  = 16'h0100;
        model_matrix[5]  = 16'h0100;
        model_matrix[10] = 16'h0100;
        model_matrix[15] = 16'h0100;
    endtask

    task automatic set_scale_translate();
        model_matrix     = '0;
        model_matrix[0]  = 16'h0280;
        model_matrix[5]  = 16'h0280;
        model_matrix[10] = 16'h0280;
        model_matrix[3]  = 16'h0100;
        model_matrix[7]  = 16'h0000;
        model_matrix[11] = 16'hFE00;
        model_matrix[15] = 16'h0100;
    endtask

    // Present a vertex and return #1 after the accepting edge
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        int n;
        vx = x; vy = y; vz = z;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises; -1 on timeout
    task automatic wait_result(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #12;
        checks++;
        if ({in_ready, out_valid, overflow, ox, oy, oz, ow} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b ovf=%b o=%h_%h_%h_%h required all zero",
                     in_ready, out_valid, overflow, ox, oy, oz, ow);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_identity();
        int lat;
        set_identity();
        send(16'h0100, 16'h0200, 16'h0300);
        wait_result(lat);
        checks++;
        if (lat !== 16) begin
            errors++; $display("FAIL identity_latency: got %0d required 16", lat);
        end
        checks++;
        if ({ox, oy, oz, ow} !== 64'h0100_0200_0300_0100) begin
            errors++; $display("FAIL identity_result: got %h_%h_%h_%h required 0100_0200_0300_0100", ox, oy, oz, ow);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL identity_overflow: got %b required 0", overflow);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_scale_translate();
        int lat;
        set_scale_translate();
        send(16'h0100, 16'h0100, 16'h0100);
        wait_result(lat);
        checks++;
        if ({ox, oy, oz, ow} !== 64'h0380_0280_0080_0100) begin
            errors++; $display("FAIL scale_translate: got %h_%h_%h_%h required 0380_0280_0080_0100", ox, oy, oz, ow);
        end
        @(posedge Clk); #1;
    endtask

    // -0.5 * (1/256) = -1/512 must floor to -1 LSB; 0.5 * (1/256) floors to 0
    task automatic test_truncation();
        int lat;
        model_matrix    = '0;
        model_matrix[0] = 16'h0001;
        model_matrix[5] = 16'h0001;
        send(16'hFF80, 16'h0080, 16'h0000);
        wait_result(lat);
        checks++;
        if ({ox, oy, oz, ow} !== 64'hFFFF_0000_0000_0000) begin
            errors++; $display("FAIL truncation: got %h_%h_%h_%h required FFFF_0000_0000_0000", ox, oy, oz, ow);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_saturation();
        int lat;
        model_matrix    = '0;
        model_matrix[0] = 16'h7FFF;
        send(16'h7FFF, 16'h0000, 16'h0000);
        wait_result(lat);
        checks++;
        if ({ox, oy, oz, ow, overflow} !== {64'h7FFF_0000_0000_0000, 1'b1}) begin
            errors++; $display("FAIL sat_pos: got %h_%h_%h_%h ovf=%b required 7FFF_0000_0000_0000 ovf=1", ox, oy, oz, ow, overflow);
        end
        @(posedge Clk); #1;
        model_matrix[0] = 16'h8000;
        send(16'h7FFF, 16'h0000, 16'h0000);
        wait_result(lat);
        checks++;
        if ({ox, overflow} !== {16'h8000, 1'b1}) begin
            errors++; $display("FAIL sat_neg: got ox=%h ovf=%b required ox=8000 ovf=1", ox, overflow);
        end
        @(posedge Clk); #1;
        set_identity();
        send(16'h0100, 16'h0200, 16'h0300);
        wait_result(lat);
        checks++;
        if ({ox, oy, oz, ow, overflow} !== {64'h0100_0200_0300_0100, 1'b0}) begin
            errors++; $display("FAIL sat_clear: got %h_%h_%h_%h ovf=%b required 0100_0200_0300_0100 ovf=0", ox, oy, oz, ow, overflow);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        set_scale_translate();
        out_ready = 1'b0;
        send(16'h0100, 16'h0100, 16'h0100);
        wait_result(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {ox, oy, oz, ow} !== 64'h0380_0280_0080_0100)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL backpressure_hold: got %0d unstable cycles required 0 (vld=%b rdy=%b)", bad, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL backpressure_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge Clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_transfer: got vld=%b required 0", out_valid);
        end
    endtask

    // With out_ready high each vertex completes its transfer 17 edges after accept
    task automatic test_back_to_back();
        int lat;
        set_identity();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send(16'h0040, 16'hFF00, 16'h0500);
            else        send(16'hFE00, 16'h0080, 16'h0001);
            wait_result(lat);
            @(posedge Clk); #1;
            checks++;
            if (lat !== 16 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL back_to_back_%0d: got lat=%0d vld=%b rdy=%b required lat=16 vld=0 rdy=1", k, lat, out_valid, in_ready);
            end
        end
        checks++;
        if ({ox, oy, oz, ow} !== 64'hFE00_0080_0001_0100) begin
            errors++; $display("FAIL back_to_back_result: got %h_%h_%h_%h required FE00_0080_0001_0100", ox, oy, oz, ow);
        end
    endtask

    task automatic test_snapshot();
        int lat;
        set_scale_translate();
        send(16'h0100, 16'h0100, 16'h0100);
        model_matrix = '0;
        wait_result(lat);
        checks++;
        if ({ox, oy, oz, ow} !== 64'h0380_0280_0080_0100) begin
            errors++; $display("FAIL snapshot: got %h_%h_%h_%h required 0380_0280_0080_0100", ox, oy, oz, ow);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_mac();
        int lat;
        set_identity();
        send(16'h0200, 16'h0300, 16'h0400);
        for (int i = 0; i < 7; i++) begin
            @(posedge Clk); #1;
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, overflow, ox, oy, oz, ow} !== 67'd0) begin
            errors++; $display("FAIL reset_mid_mac: got vld=%b rdy=%b ovf=%b o=%h_%h_%h_%h required all zero",
                               out_valid, in_ready, overflow, ox, oy, oz, ow);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        set_scale_translate();
        send(16'h0100, 16'h0100, 16'h0100);
        wait_result(lat);
        checks++;
        if (lat !== 16 || {ox, oy, oz, ow} !== 64'h0380_0280_0080_0100) begin
            errors++; $display("FAIL after_reset_vertex: got lat=%0d o=%h_%h_%h_%h required lat=16 o=0380_0280_0080_0100", lat, ox, oy, oz, ow);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        model_matrix = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        vx = 16'h0; vy = 16'h0; vz = 16'h0;
        test_reset();
        test_identity();
        test_scale_translate();
        test_truncation();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_snapshot();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
